// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
//   state_e  : loader FSM states
//   ERR_*    : values reported on err_code
//   WORD_W   : processor word width
package loader_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

  typedef enum logic [2:0] {
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
    StCsum,
    StRun,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/byte_pair_assembler.sv
// Packs consecutive hi/lo bytes into one word and pulses word_valid for one cycle
// after the lo byte is taken. With LOADER_CHECKSUM_EN it also keeps the running
// XOR of every data byte it is handed.
//   clk, rst    : clock, asynchronous active-high reset
//   byte_data   : incoming byte
//   hi_load     : capture byte_data as the high byte
//   lo_load     : combine held high byte with byte_data into word
//   acc_clear   : (checksum build) zero the running XOR
//   word        : last assembled word {hi, lo}
//   word_valid  : one-cycle pulse, word is fresh
//   csum        : (checksum build) XOR of all data bytes since acc_clear
module byte_pair_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_data,
  input  logic              hi_load,
  input  logic              lo_load,
`ifdef LOADER_CHECKSUM_EN
  input  logic              acc_clear,
  output logic [7:0]        csum,
`endif
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [7:0]        hi_q;
  logic [WORD_W-1:0] word_q;
  logic              word_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q         <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= lo_load;
      if (hi_load) hi_q <= byte_data;
      if (lo_load) word_q <= {hi_q, byte_data};
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else if (acc_clear) begin
      csum_q <= '0;
    end else if (hi_load || lo_load) begin
      csum_q <= csum_q ^ byte_data;
    end
  end

  assign csum = csum_q;
`endif

endmodule

// File: rtl/program_loader.sv
// Boot-stage loader: receives LEN_HI, LEN_LO, N x (HI, LO) [, CSUM] over a byte
// valid/ready handshake, writes the N words to processor memory at 0..N-1, then
// starts the processor and waits for it to finish (or time out).
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
//   clk, rst       : clock, asynchronous active-high reset
//   byte_valid/data: host byte stream; byte_ready accepts
//   clear          : leave DONE/ERR back to LEN_HI
//   mem_we/addr/wdata : one-cycle word write to processor memory
//   cpu_valid_in   : processor start; cpu_valid_out: processor finished
//   busy/done/err/err_code : host status
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              clear,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_valid_in,
  input  logic              cpu_valid_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned IdxW  = ADDR_W + 1;  // must hold N == DEPTH

  state_e            state_q, state_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [7:0]        len_hi_q;
  logic [IdxW-1:0]   n_q, idx_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       run_cnt_q;
  logic              byte_ready_q, byte_ready_d;
  logic              cpu_valid_in_q, cpu_valid_in_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic        xfer, hi_load, lo_load, len_bad, last_written, timeout_hit;
  logic [15:0] len_word;

  assign xfer     = byte_valid & byte_ready_q;
  assign hi_load  = (state_q == StDataHi) && xfer;
  assign lo_load  = (state_q == StDataLo) && xfer;
  assign len_word = {len_hi_q, byte_data};
  assign len_bad  = (len_word == 16'd0) || (32'(len_word) > DEPTH);
  // idx_q was bumped on the lo byte, so during the write it equals words written
  assign last_written = mem_we && (idx_q == n_q);
  assign timeout_hit  = (TIMEOUT != 0) && (run_cnt_q == TIMEOUT - 1);

`ifdef LOADER_CHECKSUM_EN
  logic       acc_clear;
  logic [7:0] csum;
  assign acc_clear = (state_q == StLenLo) && xfer;
`endif

  byte_pair_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_data  (byte_data),
    .hi_load    (hi_load),
    .lo_load    (lo_load),
`ifdef LOADER_CHECKSUM_EN
    .acc_clear  (acc_clear),
    .csum       (csum),
`endif
    .word       (mem_wdata),
    .word_valid (mem_we)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StLenHi;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    unique case (state_q)
      StLenHi: if (xfer) state_d = StLenLo;
      StLenLo: begin
        if (xfer) begin
          if (len_bad) begin
            state_d    = StErr;
            err_code_d = ERR_LEN;
          end else begin
            state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        if (last_written) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StCsum;
`else
          state_d = StRun;
`endif
        end else if (xfer) begin
          state_d = StDataLo;
        end
      end
      StDataLo: if (xfer) state_d = StDataHi;
      StCsum: begin
`ifdef LOADER_CHECKSUM_EN
        if (xfer) begin
          if (byte_data == csum) begin
            state_d = StRun;
          end else begin
            state_d    = StErr;
            err_code_d = ERR_CSUM;
          end
        end
`else
        state_d = StLenHi;
`endif
      end
      StRun: begin
        // valid_out wins over a coincident timeout
        if (cpu_valid_out) begin
          state_d = StDone;
        end else if (timeout_hit) begin
          state_d    = StErr;
          err_code_d = ERR_TIMEOUT;
        end
      end
      StDone, StErr: begin
        if (clear) begin
          state_d    = StLenHi;
          err_code_d = ERR_NONE;
        end
      end
      default: state_d = StLenHi;
    endcase
  end

  // Output logic, computed from the next state so every output is a flop
  always_comb begin
    byte_ready_d   = 1'b0;
    cpu_valid_in_d = 1'b0;
    busy_d         = 1'b1;
    done_d         = 1'b0;
    err_d          = 1'b0;
    unique case (state_d)
      StLenHi:                    begin byte_ready_d = 1'b1; busy_d = 1'b0; end
      StLenLo, StDataHi, StCsum:  byte_ready_d = !lo_load;
      StDataLo:                   byte_ready_d = 1'b1;
      StRun:                      cpu_valid_in_d = 1'b1;
      StDone:                     begin busy_d = 1'b0; done_d = 1'b1; end
      StErr:                      begin busy_d = 1'b0; err_d = 1'b1; end
      default:                    busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_ready_q   <= 1'b0;
      cpu_valid_in_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      byte_ready_q   <= byte_ready_d;
      cpu_valid_in_q <= cpu_valid_in_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  // Datapath: length, word index, write address, RUN cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_hi_q   <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      mem_addr_q <= '0;
      run_cnt_q  <= '0;
    end else begin
      if ((state_q == StLenHi) && xfer) len_hi_q <= byte_data;
      if ((state_q == StLenLo) && xfer) begin
        n_q   <= len_word[IdxW-1:0];
        idx_q <= '0;
      end
      if (lo_load) begin
        mem_addr_q <= idx_q[ADDR_W-1:0];
        idx_q      <= idx_q + 1'b1;
      end
      run_cnt_q <= (state_q == StRun) ? run_cnt_q + 32'd1 : 32'd0;
    end
  end

  assign byte_ready   = byte_ready_q;
  assign mem_addr     = mem_addr_q;
  assign cpu_valid_in = cpu_valid_in_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = err_code_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader (ADDR_W = 8, TIMEOUT = 50).
// Build with LOADER_CHECKSUM_EN to also exercise the checksum byte.
module tb_program_loader;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned TIMEOUT = 50;
  localparam int unsigned DEPTH   = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              clear = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_valid_in;
  logic              cpu_valid_out = 1'b0;
  logic              busy, done, err;
  logic [1:0]        err_code;

  program_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (byte_ready),
    .clear         (clear),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .cpu_valid_in  (cpu_valid_in),
    .cpu_valid_out (cpu_valid_out),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .err_code      (err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_we_cyc = 0;
  int gap_mode = 0;     // 0 none, 1 idle cycle before every byte, 2 random idles
  int csum_flip = 0;    // XORed into the checksum byte the host sends

  logic [15:0]       exp_words[$];
  logic [ADDR_W-1:0] wr_addr[$];
  logic [15:0]       wr_data[$];

  always @(posedge clk) cyc++;

  // Memory-side monitor: record every write strobe
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      last_we_cyc = cyc;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached (got hang, required finish)");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    int w;
    if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(2) == 0)) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    w = 0;
    while (byte_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      n_checks++;
      $display("FAIL byte_ready_wait: got no ready in 200 cycles, required ready");
    end
    @(posedge clk);
  endtask

  // Sends the whole stream for exp_words and waits for the processor start.
  task automatic do_load(output bit started);
    int unsigned n;
    logic [7:0] x;
    int w;
    n = exp_words.size();
    x = 8'h00;
    wr_addr.delete();
    wr_data.delete();
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    foreach (exp_words[i]) begin
      send_byte(exp_words[i][15:8]);
      send_byte(exp_words[i][7:0]);
      x = x ^ exp_words[i][15:8] ^ exp_words[i][7:0];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x ^ 8'(csum_flip));
`endif
    @(negedge clk);
    byte_valid = 1'b0;
    w = 0;
    while (cpu_valid_in !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    started = (w < 50);
    if (csum_flip != 0) return;
    n_checks++;
    if (!started) $display("FAIL run_start: cpu_valid_in=%b, required 1", cpu_valid_in);
    else n_pass++;
    n_checks++;
    if (wr_addr.size() != n) $display("FAIL write_count: got %0d writes, required %0d",
                                      wr_addr.size(), n);
    else n_pass++;
    for (int i = 0; i < int'(n) && i < wr_addr.size(); i++) begin
      n_checks++;
      if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== exp_words[i])
        $display("FAIL write_%0d: got addr %0d data %h, required addr %0d data %h",
                 i, wr_addr[i], wr_data[i], i, exp_words[i]);
      else n_pass++;
    end
    n_checks++;
    if (!(cyc > last_we_cyc) || busy !== 1'b1)
      $display("FAIL start_order: start cyc %0d last write cyc %0d busy %b, required later/1",
               cyc, last_we_cyc, busy);
    else n_pass++;
  endtask

  // Processor model answers after lat cycles; then status and clear are checked.
  task automatic finish_run(input int lat);
    repeat (lat) @(negedge clk);
    cpu_valid_out = 1'b1;
    @(negedge clk);
    cpu_valid_out = 1'b0;
    n_checks++;
    if ({done, err, err_code, cpu_valid_in} !== 5'b1_0_00_0)
      $display("FAIL done_status: got done %b err %b code %0d cvi %b, required 1 0 0 0",
               done, err, err_code, cpu_valid_in);
    else n_pass++;
    clear = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || byte_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL done_sticky: got done %b ready %b busy %b, required 1 0 0",
               done, byte_ready, busy);
    else n_pass++;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_checks++;
    if (done !== 1'b0 || byte_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL clear_done: got done %b ready %b busy %b, required 0 1 0",
               done, byte_ready, busy);
    else n_pass++;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({byte_ready, mem_we, mem_addr, mem_wdata, cpu_valid_in, busy, done, err, err_code} !== '0)
      $display("FAIL reset_outputs: got ready %b we %b addr %h data %h cvi %b busy %b done %b err %b code %0d, required all 0",
               byte_ready, mem_we, mem_addr, mem_wdata, cpu_valid_in, busy, done, err, err_code);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (byte_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_idle: got ready %b busy %b, required 1 0", byte_ready, busy);
    else n_pass++;
  endtask

  task automatic test_normal(input int mode);
    bit ok;
    gap_mode = mode;
    exp_words = '{16'h1234, 16'hABCD, 16'h004C};
    do_load(ok);
    if (ok) finish_run(20);
  endtask

  task automatic test_bad_length();
    logic [15:0] lens[2];
    lens = '{16'h0000, 16'h0101};
    gap_mode = 0;
    foreach (lens[k]) begin
      wr_addr.delete();
      send_byte(lens[k][15:8]);
      send_byte(lens[k][7:0]);
      @(negedge clk);
      byte_valid = 1'b0;
      n_checks++;
      if ({err, err_code, busy, byte_ready} !== 5'b1_01_0_0 || wr_addr.size() != 0)
        $display("FAIL bad_len_%h: got err %b code %0d busy %b ready %b writes %0d, required 1 1 0 0 0",
                 lens[k], err, err_code, busy, byte_ready, wr_addr.size());
      else n_pass++;
      do_clear();
      n_checks++;
      if ({err, err_code, byte_ready} !== 4'b0_00_1)
        $display("FAIL clear_err_%h: got err %b code %0d ready %b, required 0 0 1",
                 lens[k], err, err_code, byte_ready);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int elapsed;
    int dropped;
    gap_mode = 0;
    exp_words = '{16'(($urandom))};
    do_load(ok);
    if (!ok) return;
    elapsed = 0;
    dropped = 0;
    while (err !== 1'b1 && elapsed < 200) begin
      if (cpu_valid_in !== 1'b1) dropped++;
      @(negedge clk);
      elapsed++;
    end
    n_checks++;
    if (elapsed != TIMEOUT || dropped != 0)
      $display("FAIL timeout_cycles: got %0d cycles (%0d start drops), required %0d (0)",
               elapsed, dropped, TIMEOUT);
    else n_pass++;
    n_checks++;
    if ({err, err_code, cpu_valid_in, done} !== 5'b1_10_0_0)
      $display("FAIL timeout_status: got err %b code %0d cvi %b done %b, required 1 2 0 0",
               err, err_code, cpu_valid_in, done);
    else n_pass++;
    do_clear();
  endtask

  // valid_out arriving in the very cycle the timeout fires must win
  task automatic test_tie();
    bit ok;
    gap_mode = 0;
    exp_words = '{16'(($urandom)), 16'(($urandom))};
    do_load(ok);
    if (ok) finish_run(TIMEOUT - 1);
  endtask

  task automatic test_full_depth();
    bit ok;
    gap_mode = 0;
    exp_words.delete();
    for (int i = 0; i < int'(DEPTH); i++) exp_words.push_back(16'($urandom));
    do_load(ok);
    if (ok) finish_run(5);
  endtask

  task automatic test_random_loads();
    bit ok;
    for (int it = 0; it < 6; it++) begin
      gap_mode = 2;
      exp_words.delete();
      for (int i = 0; i < int'($urandom_range(12, 1)); i++) exp_words.push_back(16'($urandom));
      do_load(ok);
      if (ok) finish_run(int'($urandom_range(40, 1)));
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    gap_mode = 0;
    wr_addr.delete();
    send_byte(8'h00);
    send_byte(8'h03);
    for (int i = 0; i < 2; i++) begin
      send_byte(8'($urandom));
      send_byte(8'($urandom));
    end
    @(negedge clk);
    byte_valid = 1'b0;
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'd1)
      $display("FAIL mid_second_write: got we %b addr %0d, required 1 1", mem_we, mem_addr);
    else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({mem_we, byte_ready, busy, cpu_valid_in} !== 4'b0)
      $display("FAIL mid_async_reset: got we %b ready %b busy %b cvi %b, required 0 0 0 0",
               mem_we, byte_ready, busy, cpu_valid_in);
    else n_pass++;
    #1 rst = 1'b0;
    exp_words = '{16'h5A5A};
    do_load(ok);
    if (!ok) return;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (cpu_valid_in !== 1'b0 || busy !== 1'b0)
      $display("FAIL run_async_reset: got cvi %b busy %b, required 0 0", cpu_valid_in, busy);
    else n_pass++;
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (byte_ready !== 1'b1 || done !== 1'b0)
      $display("FAIL after_reset_idle: got ready %b done %b, required 1 0", byte_ready, done);
    else n_pass++;
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    int seen_start;
    gap_mode = 0;
    exp_words = '{16'h0F0F};
    csum_flip = 0;
    do_load(ok);
    if (ok) finish_run(3);
    csum_flip = 1;
    do_load(ok);
    seen_start = ok ? 1 : 0;
    repeat (5) begin
      if (cpu_valid_in !== 1'b0) seen_start++;
      @(negedge clk);
    end
    n_checks++;
    if (seen_start != 0 || {err, err_code} !== 3'b1_11)
      $display("FAIL csum_mismatch: got start %0d err %b code %0d, required 0 1 3",
               seen_start, err, err_code);
    else n_pass++;
    csum_flip = 0;
    do_clear();
  endtask
`endif

  initial begin
    test_reset();
    test_normal(0);
    test_normal(1);
    test_bad_length();
    test_timeout();
    test_tie();
    test_reset_mid();
    test_full_depth();
    test_random_loads();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
